// File: rtl/accel_sched_pkg.sv
// Shared constants for the accelerator command scheduler:
// register map, STATUS/RESULT layout, dispatcher states, class codes.
package accel_sched_pkg;

    localparam logic [2:0] REG_CMD_ADDR = 3'd0;
    localparam logic [2:0] REG_CMD_LEN  = 3'd1;
    localparam logic [2:0] REG_CMD_PUSH = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_RESULT   = 3'd4;
    localparam logic [2:0] REG_CTRL     = 3'd5;

    localparam int PUSH_CLASS_LSB = 16;

    localparam int STS_CMD_LSB   = 0;
    localparam int STS_RES_LSB   = 8;
    localparam int STS_OVF_BIT   = 16;
    localparam int STS_ALLOC_LSB = 24;

    localparam int RS_TAG_LSB   = 0;
    localparam int RS_ID_LSB    = 8;
    localparam int RS_MATCH_BIT = 12;
    localparam int RS_VALID_BIT = 31;

    localparam logic [1:0] CLS_TCP  = 2'd0;
    localparam logic [1:0] CLS_UDP  = 2'd1;
    localparam logic [1:0] CLS_HTTP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_ISSUE
    } disp_state_t;

    typedef struct packed {
        logic [7:0] tag;
        logic [3:0] id;
        logic       match;
    } result_t;

endpackage

// File: rtl/accel_sync_fifo.sv
// Synchronous FIFO with occupancy count and flush; a push is
// accepted when full if a pop happens in the same cycle.
module accel_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic             do_push;
    logic             do_pop;

    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty && !flush;
    assign do_push  = push && (flush || !full || do_pop);
    // flush empties first, so a concurrent push lands in slot 0
    assign wr_idx   = flush ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : '0;
            count  <= do_push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/accel_cmd_sched.sv
// Queued command dispatch to SME accelerators by class, with
// per-accelerator completion/match tracking and a result queue.
module accel_cmd_sched
    import accel_sched_pkg::*;
#(
    parameter int IO_DATA_WIDTH = 32,
    parameter int IO_ADDR_WIDTH = 22,
    parameter int ADDR_WIDTH    = 16,
    parameter int LEN_WIDTH     = 14,
    parameter int ACCEL_COUNT   = 6,
    parameter logic [2*ACCEL_COUNT-1:0] CLASS_MAP =
        {CLS_HTTP, CLS_HTTP, CLS_UDP, CLS_UDP, CLS_TCP, CLS_TCP},
    parameter int CMD_DEPTH     = 16,
    parameter int RES_DEPTH     = 16,
    parameter int TAG_WIDTH     = 8,
    localparam int ID_W = $clog2(ACCEL_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     io_en,
    input  logic                     io_wen,
    input  logic [IO_ADDR_WIDTH-1:0] io_addr,
    input  logic [IO_DATA_WIDTH-1:0] io_wr_data,
    output logic [IO_DATA_WIDTH-1:0] io_rd_data,
    output logic                     io_rd_valid,
    output logic [ID_W-1:0]          desc_accel_id,
    output logic [ADDR_WIDTH-1:0]    desc_addr,
    output logic [LEN_WIDTH-1:0]     desc_len,
    output logic                     desc_valid,
    input  logic                     desc_ready,
    output logic [ACCEL_COUNT-1:0]   accel_init,
    input  logic [ACCEL_COUNT-1:0]   accel_busy,
    input  logic [ACCEL_COUNT-1:0]   accel_done,
    input  logic [ACCEL_COUNT-1:0]   accel_match
);

    localparam int CMD_W  = ADDR_WIDTH + LEN_WIDTH + TAG_WIDTH + 2;
    localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
    localparam int RES_CW = $clog2(RES_DEPTH) + 1;

    logic [2:0] reg_sel;
    logic       wr;
    logic       rd;
    logic       unused_bits;

    assign reg_sel = io_addr[4:2];
    assign wr      = io_en && io_wen;
    assign rd      = io_en && !io_wen;
    assign unused_bits = ^{io_addr[1:0],
                           io_addr[IO_ADDR_WIDTH-1:5],
                           io_wr_data[IO_DATA_WIDTH-1:18]};

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  cmd_ovf;
    logic                  cmd_push;
    logic                  cmd_pop;
    logic                  cmd_flush;
    logic                  cmd_full;
    logic                  cmd_empty;
    logic [CMD_CW-1:0]     cmd_count;
    logic [CMD_W-1:0]      cmd_in;
    logic [CMD_W-1:0]      cmd_head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [LEN_WIDTH-1:0]  head_len;
    logic [TAG_WIDTH-1:0]  head_tag;
    logic [1:0]            head_cls;

    assign cmd_push  = wr && reg_sel == REG_CMD_PUSH;
    assign cmd_flush = wr && reg_sel == REG_CTRL && io_wr_data[1];
    assign cmd_in    = {addr_q, len_q, io_wr_data[TAG_WIDTH-1:0],
                        io_wr_data[PUSH_CLASS_LSB +: 2]};
    assign {head_addr, head_len, head_tag, head_cls} = cmd_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            len_q   <= '0;
            cmd_ovf <= 1'b0;
        end else begin
            if (wr && reg_sel == REG_CMD_ADDR) begin
                addr_q <= io_wr_data[ADDR_WIDTH-1:0];
            end
            if (wr && reg_sel == REG_CMD_LEN) begin
                len_q <= io_wr_data[LEN_WIDTH-1:0];
            end
            if (wr && reg_sel == REG_CTRL && io_wr_data[0]) begin
                cmd_ovf <= 1'b0;
            end else if (cmd_push && cmd_full
                         && !cmd_pop && !cmd_flush) begin
                cmd_ovf <= 1'b1;
            end
        end
    end

    accel_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (cmd_flush),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .count     (cmd_count),
        .full      (cmd_full),
        .empty     (cmd_empty)
    );

    disp_state_t            state;
    logic [TAG_WIDTH-1:0]   lat_tag;
    logic [ACCEL_COUNT-1:0] alloc;
    logic [ACCEL_COUNT-1:0] pending;
    logic [ACCEL_COUNT-1:0] sticky;
    logic [ACCEL_COUNT-1:0] idle_vec;
    logic [ACCEL_COUNT-1:0] done_eff;
    logic [TAG_WIDTH-1:0]   tag_q [ACCEL_COUNT];
    logic [ID_W-1:0]        first_idle;
    logic [ID_W-1:0]        res_idx;
    logic                   issue_fire;

    // a done seen this cycle can be reported without waiting a cycle
    assign done_eff = pending | (accel_done & alloc);

    always_comb begin
        idle_vec   = '0;
        first_idle = '0;
        res_idx    = '0;
        for (int i = ACCEL_COUNT - 1; i >= 0; i--) begin
            idle_vec[i] = CLASS_MAP[2*i +: 2] == head_cls
                          && !alloc[i] && !accel_busy[i]
                          && !pending[i];
            if (idle_vec[i]) begin
                first_idle = ID_W'(i);
            end
            if (done_eff[i]) begin
                res_idx = ID_W'(i);
            end
        end
    end

    assign cmd_pop    = state == ST_IDLE && !cmd_empty && |idle_vec;
    assign issue_fire = state == ST_ISSUE && desc_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            lat_tag       <= '0;
            accel_init    <= '0;
            desc_valid    <= 1'b0;
            desc_accel_id <= '0;
            desc_addr     <= '0;
            desc_len      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_pop) begin
                        desc_accel_id <= first_idle;
                        desc_addr     <= head_addr;
                        desc_len      <= head_len;
                        lat_tag       <= head_tag;
                        accel_init    <= ACCEL_COUNT'(1) << first_idle;
                        state         <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    accel_init <= '0;
                    desc_valid <= 1'b1;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (desc_ready) begin
                        desc_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic    res_push;
    logic    res_pop;
    logic    res_full;
    logic    res_empty;
    logic [RES_CW-1:0] res_count;
    result_t res_in;
    result_t res_head;

    assign res_pop  = rd && reg_sel == REG_RESULT && !res_empty;
    assign res_push = |done_eff && (!res_full || res_pop);

    always_comb begin
        res_in       = '0;
        res_in.tag   = 8'(tag_q[res_idx]);
        res_in.id    = 4'(res_idx);
        res_in.match = sticky[res_idx]
                       | (accel_match[res_idx] & alloc[res_idx]);
    end

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            tag_q[desc_accel_id] <= lat_tag;
        end
    end

    // a stalled result keeps the accelerator allocated and pending
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc   <= '0;
            pending <= '0;
            sticky  <= '0;
        end else begin
            for (int i = 0; i < ACCEL_COUNT; i++) begin
                if (res_push && res_idx == ID_W'(i)) begin
                    alloc[i]   <= 1'b0;
                    pending[i] <= 1'b0;
                end else begin
                    if (issue_fire && desc_accel_id == ID_W'(i)) begin
                        alloc[i] <= 1'b1;
                    end
                    if (accel_done[i] && alloc[i]) begin
                        pending[i] <= 1'b1;
                    end
                end
                if (state == ST_INIT && desc_accel_id == ID_W'(i)) begin
                    sticky[i] <= 1'b0;
                end else if (alloc[i] && accel_match[i]) begin
                    sticky[i] <= 1'b1;
                end
            end
        end
    end

    accel_sync_fifo #(.WIDTH($bits(result_t)), .DEPTH(RES_DEPTH))
    u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (res_push),
        .push_data (res_in),
        .pop       (res_pop),
        .pop_data  (res_head),
        .count     (res_count),
        .full      (res_full),
        .empty     (res_empty)
    );

    logic [31:0] rd_word;

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_word[STS_CMD_LSB +: 8]   = 8'(cmd_count);
                rd_word[STS_RES_LSB +: 8]   = 8'(res_count);
                rd_word[STS_OVF_BIT]        = cmd_ovf;
                rd_word[STS_ALLOC_LSB +: 8] = 8'(alloc);
            end
            REG_RESULT: begin
                if (!res_empty) begin
                    rd_word[RS_TAG_LSB +: 8] = res_head.tag;
                    rd_word[RS_ID_LSB +: 4]  = res_head.id;
                    rd_word[RS_MATCH_BIT]    = res_head.match;
                    rd_word[RS_VALID_BIT]    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_rd_valid <= 1'b0;
            io_rd_data  <= '0;
        end else begin
            io_rd_valid <= rd;
            io_rd_data  <= rd ? IO_DATA_WIDTH'(rd_word) : '0;
        end
    end

endmodule

// File: tb/tb_accel_cmd_sched.sv
// Directed scenario bench for accel_cmd_sched with
// hand-computed register and descriptor values.
module tb_accel_cmd_sched;
    import accel_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_en;
    logic        io_wen;
    logic [21:0] io_addr;
    logic [31:0] io_wr_data;
    logic [31:0] io_rd_data;
    logic        io_rd_valid;
    logic [2:0]  desc_accel_id;
    logic [15:0] desc_addr;
    logic [13:0] desc_len;
    logic        desc_valid;
    logic        desc_ready;
    logic [5:0]  accel_init;
    logic [5:0]  accel_busy;
    logic [5:0]  accel_done;
    logic [5:0]  accel_match;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    accel_cmd_sched dut (
        .clk           (clk),
        .rst           (rst),
        .io_en         (io_en),
        .io_wen        (io_wen),
        .io_addr       (io_addr),
        .io_wr_data    (io_wr_data),
        .io_rd_data    (io_rd_data),
        .io_rd_valid   (io_rd_valid),
        .desc_accel_id (desc_accel_id),
        .desc_addr     (desc_addr),
        .desc_len      (desc_len),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .accel_init    (accel_init),
        .accel_busy    (accel_busy),
        .accel_done    (accel_done),
        .accel_match   (accel_match)
    );

    task automatic io_write(input logic [2:0] r, input logic [31:0] d);
        io_en      = 1'b1;
        io_wen     = 1'b1;
        io_addr    = {17'b0, r, 2'b00};
        io_wr_data = d;
        @(negedge clk);
        io_en  = 1'b0;
        io_wen = 1'b0;
    endtask

    task automatic io_read(input logic [2:0] r,
                           output logic [31:0] d, output logic v);
        io_en   = 1'b1;
        io_wen  = 1'b0;
        io_addr = {17'b0, r, 2'b00};
        @(negedge clk);
        io_en = 1'b0;
        d = io_rd_data;
        v = io_rd_valid;
    endtask

    task automatic push_cmd(input logic [15:0] a, input logic [13:0] l,
                            input logic [7:0] t, input logic [1:0] c);
        io_write(REG_CMD_ADDR, {16'b0, a});
        io_write(REG_CMD_LEN, {18'b0, l});
        io_write(REG_CMD_PUSH, {14'b0, c, 8'b0, t});
    endtask

    task automatic pulse_done(input logic [5:0] dm, input logic [5:0] mm);
        accel_done  = dm;
        accel_match = mm;
        @(negedge clk);
        accel_done  = '0;
        accel_match = '0;
    endtask

    // Observes one INIT pulse and the following descriptor handshake.
    task automatic wait_dispatch(output logic [5:0] iv,
                                 output logic [32:0] dsc,
                                 output logic ok);
        int n = 0;
        while (accel_init === 6'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        iv = accel_init;
        @(negedge clk);
        ok  = (n < 40) && desc_valid === 1'b1 && accel_init === 6'b0;
        dsc = {desc_accel_id, desc_addr, desc_len};
        @(negedge clk);
        ok = ok && desc_valid === 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({io_rd_data, io_rd_valid, desc_valid, desc_accel_id,
             desc_addr, desc_len, accel_init} !== 73'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%h v=%b dv=%b id=%0d a=%h l=%h init=%b",
                     io_rd_data, io_rd_valid, desc_valid, desc_accel_id,
                     desc_addr, desc_len, accel_init);
        end
        rst = 1'b0;
        @(negedge clk);
        io_read(REG_STATUS, d, v);
        checks++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_status: got v=%b %h want v=1 00000000", v, d);
        end
        io_read(3'd6, d, v);
        checks++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL unmapped_read: got v=%b %h want v=1 00000000", v, d);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic        v;
        int          n = 0;
        logic [39:0] exp_o;
        exp_o = {6'b0, 1'b1, 3'd2, 16'h0100, 14'd64};
        desc_ready = 1'b0;
        push_cmd(16'h0100, 14'd64, 8'h5A, CLS_UDP);
        while (accel_init === 6'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (accel_init !== 6'b000100) begin
            errors++;
            $display("FAIL basic_init: got %b want 000100", accel_init);
        end
        @(negedge clk);
        checks++;
        if ({accel_init, desc_valid, desc_accel_id, desc_addr, desc_len} !== exp_o) begin
            errors++;
            $display("FAIL basic_issue: got %h want %h",
                     {accel_init, desc_valid, desc_accel_id, desc_addr, desc_len}, exp_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({accel_init, desc_valid, desc_accel_id, desc_addr, desc_len} !== exp_o) begin
            errors++;
            $display("FAIL basic_stall_hold: got %h want %h",
                     {accel_init, desc_valid, desc_accel_id, desc_addr, desc_len}, exp_o);
        end
        desc_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_handshake: desc_valid=%b want 0", desc_valid);
        end
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h0400_0000) begin
            errors++;
            $display("FAIL basic_alloc: got %h want 04000000", d);
        end
        pulse_done(6'b000100, 6'b0);
        io_read(REG_RESULT, d, v);
        checks++;
        if ({v, d} !== {1'b1, 32'h8000_025A}) begin
            errors++;
            $display("FAIL basic_result: got v=%b %h want v=1 8000025A", v, d);
        end
        @(negedge clk);
        checks++;
        if (io_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_pulse: got %b want 0", io_rd_valid);
        end
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL basic_empty_result: got %h want 00000000", d);
        end
    endtask

    task automatic test_fifo_order();
        logic [31:0] d;
        logic        v;
        logic [5:0]  iv;
        logic [32:0] dsc;
        logic        ok;
        int          seen = 0;
        push_cmd(16'h1000, 14'd10, 8'h10, CLS_TCP);
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h01 || dsc !== {3'd0, 16'h1000, 14'd10}) begin
            errors++;
            $display("FAIL order_a: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        push_cmd(16'h1100, 14'd11, 8'h11, CLS_TCP);
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h02 || dsc !== {3'd1, 16'h1100, 14'd11}) begin
            errors++;
            $display("FAIL order_b: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        push_cmd(16'h1200, 14'd12, 8'h12, CLS_TCP);
        repeat (10) begin
            @(negedge clk);
            if (accel_init !== 6'b0 || desc_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL order_wait: got %0d dispatch cycles want 0", seen);
        end
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h0300_0001) begin
            errors++;
            $display("FAIL order_status: got %h want 03000001", d);
        end
        pulse_done(6'b000001, 6'b0);
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h01 || dsc !== {3'd0, 16'h1200, 14'd12}) begin
            errors++;
            $display("FAIL order_c: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        pulse_done(6'b000010, 6'b0);
        pulse_done(6'b000001, 6'b0);
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_0010) begin
            errors++;
            $display("FAIL order_res0: got %h want 80000010", d);
        end
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_0111) begin
            errors++;
            $display("FAIL order_res1: got %h want 80000111", d);
        end
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_0012) begin
            errors++;
            $display("FAIL order_res2: got %h want 80000012", d);
        end
    endtask

    task automatic test_match_sticky();
        logic [31:0] d;
        logic        v;
        logic [5:0]  iv;
        logic [32:0] dsc;
        logic        ok;
        accel_busy = 6'b000100;
        push_cmd(16'h0300, 14'd100, 8'h33, CLS_UDP);
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h08 || dsc !== {3'd3, 16'h0300, 14'd100}) begin
            errors++;
            $display("FAIL sticky_dispatch: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        pulse_done(6'b0, 6'b001000);
        repeat (4) @(negedge clk);
        pulse_done(6'b001000, 6'b0);
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_1333) begin
            errors++;
            $display("FAIL sticky_match: got %h want 80001333", d);
        end
        push_cmd(16'h0340, 14'd20, 8'h34, CLS_UDP);
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h08 || dsc !== {3'd3, 16'h0340, 14'd20}) begin
            errors++;
            $display("FAIL sticky_redispatch: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        pulse_done(6'b001000, 6'b0);
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_0334) begin
            errors++;
            $display("FAIL sticky_cleared: got %h want 80000334", d);
        end
        accel_busy = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        v;
        logic [5:0]  iv;
        logic [32:0] dsc;
        logic        ok;
        push_cmd(16'h0400, 14'd4, 8'h40, CLS_TCP);
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h01 || dsc !== {3'd0, 16'h0400, 14'd4}) begin
            errors++;
            $display("FAIL b2b_dispatch0: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        push_cmd(16'h0440, 14'd44, 8'h44, CLS_HTTP);
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h10 || dsc !== {3'd4, 16'h0440, 14'd44}) begin
            errors++;
            $display("FAIL b2b_dispatch4: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        pulse_done(6'b010001, 6'b010000);
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h1000_0100) begin
            errors++;
            $display("FAIL b2b_first_cycle: got %h want 10000100", d);
        end
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h0000_0200) begin
            errors++;
            $display("FAIL b2b_second_cycle: got %h want 00000200", d);
        end
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_0040) begin
            errors++;
            $display("FAIL b2b_res0: got %h want 80000040", d);
        end
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_1444) begin
            errors++;
            $display("FAIL b2b_res4: got %h want 80001444", d);
        end
    endtask

    task automatic test_cmd_overflow();
        logic [31:0] d;
        logic        v;
        accel_busy = 6'h3F;
        for (int i = 0; i < 17; i++) begin
            push_cmd(16'h2000, 14'd8, 8'(i), CLS_TCP);
        end
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h0001_0010) begin
            errors++;
            $display("FAIL ovf_set: got %h want 00010010", d);
        end
        io_write(REG_CTRL, 32'h1);
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h0000_0010) begin
            errors++;
            $display("FAIL ovf_clear: got %h want 00000010", d);
        end
        io_write(REG_CTRL, 32'h2);
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL flush: got %h want 00000000", d);
        end
        accel_busy = '0;
    endtask

    task automatic test_result_full();
        logic [31:0] d;
        logic        v;
        logic [5:0]  iv;
        logic [32:0] dsc;
        logic        ok;
        int          seen = 0;
        for (int i = 0; i < 16; i++) begin
            push_cmd(16'(16'h3000 + i), 14'(i + 1), 8'(8'h60 + i), CLS_TCP);
            wait_dispatch(iv, dsc, ok);
            checks++;
            if (!ok || iv !== 6'h01
                || dsc !== {3'd0, 16'(16'h3000 + i), 14'(i + 1)}) begin
                errors++;
                $display("FAIL fill_dispatch%0d: ok=%b init=%b desc=%h", i, ok, iv, dsc);
            end
            pulse_done(6'b000001, 6'b0);
        end
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h0000_1000) begin
            errors++;
            $display("FAIL fill_status: got %h want 00001000", d);
        end
        accel_busy = 6'b010000;
        push_cmd(16'h0550, 14'd55, 8'h55, CLS_HTTP);
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h20 || dsc !== {3'd5, 16'h0550, 14'd55}) begin
            errors++;
            $display("FAIL full_dispatch5: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        pulse_done(6'b100000, 6'b0);
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h2000_1000) begin
            errors++;
            $display("FAIL full_pending: got %h want 20001000", d);
        end
        push_cmd(16'h0560, 14'd56, 8'h56, CLS_HTTP);
        repeat (10) begin
            @(negedge clk);
            if (accel_init !== 6'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL full_no_redispatch: got %0d init cycles want 0", seen);
        end
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_0060) begin
            errors++;
            $display("FAIL full_pop: got %h want 80000060", d);
        end
        io_read(REG_STATUS, d, v);
        checks++;
        if (d !== 32'h0000_1001) begin
            errors++;
            $display("FAIL full_refill: got %h want 00001001", d);
        end
        wait_dispatch(iv, dsc, ok);
        checks++;
        if (!ok || iv !== 6'h20 || dsc !== {3'd5, 16'h0560, 14'd56}) begin
            errors++;
            $display("FAIL full_redispatch5: ok=%b init=%b desc=%h", ok, iv, dsc);
        end
        for (int i = 1; i < 16; i++) begin
            io_read(REG_RESULT, d, v);
            checks++;
            if (d !== (32'h8000_0060 + 32'(i))) begin
                errors++;
                $display("FAIL drain%0d: got %h want %h", i, d, 32'h8000_0060 + 32'(i));
            end
        end
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_0555) begin
            errors++;
            $display("FAIL held_record: got %h want 80000555", d);
        end
        pulse_done(6'b100000, 6'b0);
        io_read(REG_RESULT, d, v);
        checks++;
        if (d !== 32'h8000_0556) begin
            errors++;
            $display("FAIL last_record: got %h want 80000556", d);
        end
        accel_busy = '0;
    endtask

    initial begin
        rst         = 1'b1;
        io_en       = 1'b0;
        io_wen      = 1'b0;
        io_addr     = '0;
        io_wr_data  = '0;
        desc_ready  = 1'b1;
        accel_busy  = '0;
        accel_done  = '0;
        accel_match = '0;
        test_reset();
        test_basic();
        test_fifo_order();
        test_match_sticky();
        test_back_to_back();
        test_cmd_overflow();
        test_result_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
